// File: rtl/elevator_scheduler_if.sv
// Signal bundle between the request scheduler and the car controller / call panel.
// The master side is the scheduler; the slave side is the car and call sources.
interface elevator_scheduler_if;
  logic [15:0] call_req;
  logic [3:0]  cur_floor;
  logic        car_at_rest;
  logic [3:0]  target_floor;
  logic [15:0] pending;
  logic        dir_up;
  logic        busy;
  logic        serve_pulse;
  logic [3:0]  served_floor;

  modport master (
    input  call_req, cur_floor, car_at_rest,
    output target_floor, pending, dir_up, busy, serve_pulse, served_floor
  );

  modport slave (
    output call_req, cur_floor, car_at_rest,
    input  target_floor, pending, dir_up, busy, serve_pulse, served_floor
  );
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler for a single elevator car: collects floor calls, picks the
// next target, performs en-route pickups and holds the car for a door dwell after each serve.
module elevator_scheduler #(
  parameter int unsigned NUM_FLOORS   = 15,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  elevator_scheduler_if.master        bus
);

  localparam logic [15:0] FLOOR_MASK = 16'((32'd1 << NUM_FLOORS) - 32'd1);
  localparam logic [7:0]  DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DWELL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  target_q, target_d;
  logic        dir_up_q, dir_up_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        serve_q, serve_d;
  logic [3:0]  served_q, served_d;

  logic [15:0] call_masked_s;
  logic [15:0] clear_s;
  logic [4:0]  up_s;
  logic [4:0]  dn_s;

  // Bit 4 flags that a pending floor was found; bits 3:0 hold the nearest one above floor.
  function automatic logic [4:0] nearest_above(input logic [15:0] pend, input logic [3:0] floor);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if ((4'(i) > floor) && pend[4'(i)]) begin
        res = {1'b1, 4'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [4:0] nearest_below(input logic [15:0] pend, input logic [3:0] floor);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i <= 15; i++) begin
      if ((4'(i) < floor) && pend[4'(i)]) begin
        res = {1'b1, 4'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state, next-target and pending-bitmap update.
  always_comb begin
    call_masked_s = bus.call_req & FLOOR_MASK;
    up_s          = nearest_above(pending_q, bus.cur_floor);
    dn_s          = nearest_below(pending_q, bus.cur_floor);
    clear_s       = 16'd0;
    state_d       = state_q;
    target_d      = target_q;
    dir_up_d      = dir_up_q;
    dwell_d       = dwell_q;
    serve_d       = 1'b0;
    served_d      = served_q;

    case (state_q)
      S_IDLE: begin
        target_d = bus.cur_floor;
        if (pending_q[bus.cur_floor]) begin
          clear_s  = 16'd1 << bus.cur_floor;
          serve_d  = 1'b1;
          served_d = bus.cur_floor;
          dwell_d  = DWELL_LOAD;
          state_d  = S_DWELL;
        end else if (pending_q != 16'd0) begin
          // With no call ahead, reverse: the opposite side must hold the remaining calls.
          if (dir_up_q ? up_s[4] : dn_s[4]) begin
            target_d = dir_up_q ? up_s[3:0] : dn_s[3:0];
          end else begin
            target_d = dir_up_q ? dn_s[3:0] : up_s[3:0];
            dir_up_d = ~dir_up_q;
          end
          state_d = S_MOVE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MOVE: begin
        if (bus.car_at_rest && (bus.cur_floor == target_q)) begin
          clear_s  = 16'd1 << target_q;
          serve_d  = 1'b1;
          served_d = target_q;
          dwell_d  = DWELL_LOAD;
          state_d  = S_DWELL;
        end else if (target_q > bus.cur_floor) begin
          if (up_s[4] && (up_s[3:0] < target_q)) begin
            target_d = up_s[3:0];
          end else begin
            target_d = target_q;
          end
        end else if (target_q < bus.cur_floor) begin
          if (dn_s[4] && (dn_s[3:0] > target_q)) begin
            target_d = dn_s[3:0];
          end else begin
            target_d = target_q;
          end
        end else begin
          target_d = target_q;
        end
      end

      S_DWELL: begin
        target_d = bus.cur_floor;
        // A repeat call for the floor being served only stretches the door time.
        if (bus.call_req[bus.cur_floor]) begin
          clear_s = 16'd1 << bus.cur_floor;
          dwell_d = DWELL_LOAD;
        end else if (dwell_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          dwell_d = dwell_q - 8'd1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        target_d = bus.cur_floor;
      end
    endcase

    pending_d = (pending_q | call_masked_s) & ~clear_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 16'd0;
      target_q  <= 4'd0;
      dir_up_q  <= 1'b1;
      dwell_q   <= 8'd0;
      serve_q   <= 1'b0;
      served_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
      dwell_q   <= dwell_d;
      serve_q   <= serve_d;
      served_q  <= served_d;
    end
  end

  assign bus.target_floor = target_q;
  assign bus.pending      = pending_q;
  assign bus.dir_up       = dir_up_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.serve_pulse  = serve_q;
  assign bus.served_floor = served_q;

endmodule
